// File: rtl/halt_result_checker.sv
// halt_result_checker: after start, counts RUN cycles until the CPU halts or a
// timeout expires, then reads back a list of data-memory words and compares
// each against its expected value, reporting pass/fail, the first failing
// entry and the run length.
module halt_result_checker #(
    parameter int     DATA_W     = 16,
    parameter int     ADDR_W     = 8,
    parameter int     NUM_CHECKS = 4,
    parameter int     RD_LAT     = 1,
    parameter int     CYC_W      = 32,
    parameter longint TIMEOUT    = 100000,
    localparam int    IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         halt,
    input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [IDX_W-1:0]             fail_idx,
    output logic [DATA_W-1:0]            fail_data,
    output logic [CYC_W-1:0]             cycles
);

    localparam int                WAIT_W    = $clog2(RD_LAT + 1);
    localparam logic [CYC_W-1:0]  TIMEOUT_C = CYC_W'(TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CHECKS - 1);
    localparam logic [WAIT_W-1:0] RD_LAT_C  = WAIT_W'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CYC_W-1:0]    cycles_inc;
    logic [DATA_W-1:0]   data_cur;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                rdata_match;
    logic                wait_last;
    logic                hit_timeout;

    // Cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign idx_nxt     = idx + 1'b1;
    assign cycles_inc  = sat_inc(cycles);
    assign data_cur    = exp_data[int'(idx) * DATA_W +: DATA_W];
    assign addr_nxt    = exp_addr[int'(idx_nxt) * ADDR_W +: ADDR_W];
    assign rdata_match = (mem_rdata == data_cur);
    assign wait_last   = (wait_cnt == WAIT_W'(1));
    assign hit_timeout = (cycles_inc == TIMEOUT_C);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; halt takes priority over a coinciding timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_RUN;
            S_RUN: begin
                if (halt)             next_state = S_READ;
                else if (hit_timeout) next_state = S_DONE;
            end
            S_READ: next_state = S_WAIT;
            S_WAIT: begin
                if (wait_last) begin
                    if (!rdata_match || idx == LAST_IDX) next_state = S_DONE;
                    else                                 next_state = S_READ;
                end
            end
            S_DONE: if (start) next_state = S_RUN;
            default: next_state = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        mem_rd = (state == S_READ);
        busy   = (state == S_RUN) || (state == S_READ) || (state == S_WAIT);
        done   = (state == S_DONE);
    end

    // Counters, read address and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles    <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_idx  <= '0;
            fail_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cycles    <= '0;
                        idx       <= '0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        fail_idx  <= '0;
                        fail_data <= '0;
                    end
                end
                S_RUN: begin
                    cycles <= cycles_inc;
                    if (halt) begin
                        idx      <= '0;
                        mem_addr <= exp_addr[ADDR_W-1:0];
                    end else if (hit_timeout) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                S_READ: wait_cnt <= RD_LAT_C;
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_last) begin
                        if (!rdata_match) begin
                            pass      <= 1'b0;
                            fail_idx  <= idx;
                            fail_data <= mem_rdata;
                        end else if (idx == LAST_IDX) begin
                            pass <= 1'b1;
                        end else begin
                            idx      <= idx_nxt;
                            mem_addr <= addr_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/halt_result_checker.md
# halt_result_checker

Synthesisable post-run self-check for the RISC machine. After the CPU is started, it counts cycles until the CPU reports HALT, or until a timeout expires. It then reads a parametrised list of data-memory words through a read port and compares each against an expected value. It reports pass/fail, the first failing entry, and the run length, which lets on-board runs (LEDR/HEX) reproduce the memory checks otherwise done only in simulation.

## Interface
Parameters:
- DATA_W, 16, memory word width
- ADDR_W, 8, memory address width
- NUM_CHECKS, 4, number of (address, expected) pairs; ≥1
- RD_LAT, 1, memory read latency in cycles; ≥1
- CYC_W, 32, cycle-counter width
- TIMEOUT, 100000, max RUN cycles before abort; 1 ≤ TIMEOUT ≤ 2^CYC_W−1

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: begin monitoring (issued as CPU reset releases)
- halt  in  1  level; CPU is in HALT state
- exp_addr  in  NUM_CHECKS*ADDR_W  entry i at bits [i*ADDR_W +: ADDR_W]
- exp_data  in  NUM_CHECKS*DATA_W  entry i at bits [i*DATA_W +: DATA_W]
- mem_rd  out  1  read strobe, one cycle per check
- mem_addr  out  ADDR_W  read address, valid while mem_rd=1
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after the mem_rd cycle
- busy  out  1  state is RUN, READ or WAIT
- done  out  1  result valid (state DONE)
- pass  out  1  all checks matched; valid when done=1
- timeout  out  1  aborted on timeout; valid when done=1
- fail_idx  out  clog2(NUM_CHECKS), min 1  index of first mismatching entry
- fail_data  out  DATA_W  mem_rdata observed at the first mismatch
- cycles  out  CYC_W  RUN-cycle count

## Operation
- States: IDLE, RUN, READ, WAIT, DONE.
- Reset (sync, highest priority) takes effect at the next edge:
  - state becomes IDLE.
  - All outputs are 0: mem_rd, mem_addr, busy, done, pass, timeout, fail_idx, fail_data, cycles.
  - The internal index idx and wait counter are 0.
- IDLE, start=1 → RUN. cycles←0, results cleared.
- RUN:
  - cycles increments every edge, including the edge that samples halt=1.
  - halt=1 → READ with idx=0.
  - Otherwise, if the incremented cycles == TIMEOUT → DONE with timeout=1, pass=0. No memory reads are issued.
  - If halt=1 on the same edge that timeout would fire, halt wins.
- READ (one cycle):
  - mem_rd=1, mem_addr=exp_addr[idx].
  - → WAIT, wait counter←RD_LAT.
- WAIT:
  - Decrement the wait counter each edge.
  - On the edge where it reaches 0, compare mem_rdata with exp_data[idx]:
    - Mismatch → DONE: pass=0, fail_idx=idx, fail_data=mem_rdata.
    - Match with idx==NUM_CHECKS−1 → DONE, pass=1.
    - Match otherwise → idx+1, READ.
- DONE:
  - Outputs are held.
  - start=1 restarts exactly as from IDLE: results cleared, cycles←0, → RUN.
- start is ignored in RUN, READ and WAIT.
- halt changes after leaving RUN are ignored.
- Comparison is a full DATA_W bitwise equality. X/Z are not special.
- cycles saturates at 2^CYC_W−1. This is unreachable given the TIMEOUT bound but required.
- mem_addr holds its last value outside READ. Only mem_rd qualifies it.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- start sampled at edge 0: RUN from edge 0, busy=1 in the following cycle.
- halt sampled in RUN at edge k: cycles=k (edges counted from the first RUN edge), READ during cycle k+1.
- Each check takes 1+RD_LAT cycles (READ plus RD_LAT WAIT cycles).
- All pass: done=1 exactly NUM_CHECKS*(1+RD_LAT) cycles after READ is first entered.
- Mismatch at entry i: done=1 after (i+1)*(1+RD_LAT) cycles.
- Timeout: done=1 in the cycle after the TIMEOUT-th RUN edge, with cycles=TIMEOUT.
- mem_rd is high for exactly one cycle per issued check. Back-to-back READs never occur, because WAIT always separates them.
- Reset during READ or WAIT: mem_rd and busy are 0 after that edge. Any in-flight read data is ignored.

## Test plan
Bench uses NUM_CHECKS=2, RD_LAT=1, exp_addr={0x15,0x14}, exp_data={0,850}, with a model memory of 1-cycle latency.
- Reset held 3 cycles → all outputs 0, state IDLE. Pulse start, then halt high at RUN edge 20 → cycles=20, two mem_rd pulses (addr 0x14 then 0x15), done=1 four cycles after READ entry, pass=1, timeout=0.
- Same run with mem[0x15]=7 → done=1, pass=0, fail_idx=1, fail_data=7. Exactly two mem_rd pulses.
- mem[0x14]=849 → fail_idx=0, fail_data=849. Only one mem_rd pulse.
- TIMEOUT=50, halt never asserted → done=1 after 50 RUN edges, cycles=50, timeout=1, pass=0, no mem_rd. Repeat with halt rising exactly at edge 50 → checks run, timeout=0.
- Reset asserted during WAIT of check 0 → next cycle all outputs 0. A later start with halt at edge 5 → normal pass, cycles=5.
- start pulsed during RUN → ignored, cycles not cleared. start pulsed in DONE → results cleared, new run completes correctly.
